magma_dec_stream: RTL and testbench
===================================

MAGMA_DEC_STREAM -- requirements
Module: magma_dec_stream

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-002 SHALL have port reset_  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port key  input  256  cipher key, K1 = key[255:224] … K8 = key[31:0].
REQ-004 SHALL have port in_valid  input  1  ciphertext block offered.
REQ-005 SHALL have port in_ready  output  1  block can be accepted.
REQ-006 SHALL have port in_data  input  64  ciphertext; [63:32] = left half, [31:0] = right half.
REQ-007 SHALL have port out_valid  output  1  plaintext block available.
REQ-008 SHALL have port out_ready  input  1  consumer takes block.
REQ-009 SHALL have port out_data  output  64  plaintext block.
REQ-010 SHALL have port busy  output  1  high in ROUND or OUTPUT state.
REQ-011 SHALL have, only with MAGMA_DEC_CBC_EN, port iv  input  64  initial chaining value.
REQ-012 SHALL have, only with MAGMA_DEC_CBC_EN, port iv_load  input  1  load iv into chain register.

Function
REQ-013 SHALL implement FSM states IDLE, ROUND, OUTPUT; in_ready = 1 only in IDLE.
REQ-014 SHALL accept a block on in_valid & in_ready: latch in_data halves and key, round counter <= 0, go to ROUND.
REQ-015 SHALL perform exactly one Magma round per clock in ROUND, 32 rounds total.
REQ-016 SHALL compute each round as: t = (right + Kr) mod 2^32; nibble j (bits 4j+3:4j) substituted by GOST R 34.12-2015 Magma table Pi_j; t rotated left 11; new right = left ^ t; new left = old right.
REQ-017 SHALL use decryption key order K1..K8, then K8..K1, K8..K1, K8..K1 for rounds 1..32.
REQ-018 SHALL form the result after round 32 as {right, left}, with no final swap, and register it into out_data.
REQ-019 SHALL assert out_valid exactly 33 cycles after the accepting edge, then enter OUTPUT.
REQ-020 SHALL hold out_valid and out_data stable in OUTPUT while out_ready = 0, for an unbounded time.
REQ-021 SHALL on out_valid & out_ready drop out_valid next cycle and return to IDLE; the next accept is earliest the following cycle.
REQ-022 SHALL ignore key and in_data changes after acceptance until the next accept.
REQ-023 SHALL ignore in_valid outside IDLE; no block is lost or duplicated.

Reset
REQ-024 SHALL on reset_ = 1 at a clock edge force IDLE, out_valid = 0, out_data = 0, busy = 0, in_ready = 0 during reset, round counter = 0, chain register = 0.
REQ-025 SHALL abort any in-flight block when reset occurs mid-ROUND or mid-OUTPUT; no out_valid follows.
REQ-026 SHALL assert in_ready in the first cycle after reset_ deasserts.

Configuration
REQ-027 SHALL use macro MAGMA_DEC_CBC_EN to select CBC decryption mode.
REQ-028 SHALL, with MAGMA_DEC_CBC_EN, set out_data = D(C) ^ chain and update chain <= C (the latched ciphertext) on the output handshake.
REQ-029 SHALL, with MAGMA_DEC_CBC_EN, load chain <= iv on iv_load only in IDLE; iv_load is ignored in other states; iv_load together with an accept in the same cycle loads iv first and that block uses it.
REQ-030 SHALL, without MAGMA_DEC_CBC_EN, operate in ECB: out_data = D(C); iv, iv_load and the chain register are absent.

Verification
REQ-031 SHALL verify ECB: key ffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, in_data 4ee901e5c2d8ca3d -> out_data fedcba9876543210, out_valid 33 cycles after accept.
REQ-032 SHALL verify backpressure: out_ready = 0 for 50 cycles -> out_valid and out_data held, in_ready = 0, a second offered block is not accepted until the handshake.
REQ-033 SHALL verify reset mid-operation: reset_ = 1 at round 10 -> out_valid = 0, out_data = 0; after release, a fresh block decrypts correctly.
REQ-034 SHALL verify key change after accept: key toggled during ROUND -> result still fedcba9876543210.
REQ-035 SHALL verify CBC (MAGMA_DEC_CBC_EN): iv = 0, two blocks of 4ee901e5c2d8ca3d -> fedcba9876543210, then b035bb7db48cf82d.
REQ-036 SHALL verify back-to-back streaming: 4 blocks with in_valid held high and out_ready = 1 -> one block per 35 cycles, outputs in order.

Source files
------------

// File: rtl/magma_dec_stream.sv
// Magma (GOST R 34.12-2015) block decryptor, one round per clock; MAGMA_DEC_CBC_EN enables CBC chaining.
// Latency: out_valid rises 33 cycles after the accepting edge; next accept one cycle after the output handshake.
// Backpressure: result held in OUTPUT while out_ready is low; in_ready is high only in IDLE.
module magma_dec_stream (
  input  logic         clk,
  input  logic         reset_,
  input  logic [255:0] key,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
`ifdef MAGMA_DEC_CBC_EN
  input  logic [63:0]  iv,
  input  logic         iv_load,
`endif
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ROUND, OUTPUT} state_t;

  // Pi_7 .. Pi_0, entry v of each table sits at bits [4v+3:4v]
  localparam logic [511:0] SBOX = {
    64'h2BC96AF43850DE71, 64'h73AD0B4FC19652E8,
    64'h0E34187BAC296FD5, 64'hC24BE390D618A5F7,
    64'hB9E35A076F4D128C, 64'h069C471EDAF2853B,
    64'hF0DB74E1C5A93286, 64'h1F307D8E9B5A264C
  };

  function automatic logic [31:0] sub_nibbles(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      r[4*j +: 4] = SBOX[64*j + 4*int'(a[4*j +: 4]) +: 4];
    end
    return r;
  endfunction

  state_t        state, next_state;
  logic [5:0]    cnt;
  logic [31:0]   left, right;
  logic [255:0]  key_r;
  logic          accept;
  logic [2:0]    kidx;
  logic [31:0]   rk, sum, sub, new_right;
`ifdef MAGMA_DEC_CBC_EN
  logic [63:0]   chain, c_lat;
`endif

  assign in_ready = (state == IDLE) && !reset_;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // Rounds 1..8 walk K1..K8, rounds 9..32 walk K8..K1 three times
  assign kidx      = (cnt < 6'd8) ? cnt[2:0] : ~cnt[2:0];
  assign rk        = key_r[{~kidx, 5'd0} +: 32];
  assign sum       = right + rk;
  assign sub       = sub_nibbles(sum);
  assign new_right = left ^ {sub[20:0], sub[31:21]};

  always_ff @(posedge clk) begin
    if (reset_) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = ROUND;
      ROUND:   if (cnt == 6'd32) next_state = OUTPUT;
      OUTPUT:  if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_) begin
      left      <= '0;
      right     <= '0;
      key_r     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef MAGMA_DEC_CBC_EN
      chain     <= '0;
      c_lat     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef MAGMA_DEC_CBC_EN
          if (iv_load) chain <= iv;
`endif
          if (accept) begin
            left  <= in_data[63:32];
            right <= in_data[31:0];
            key_r <= key;
            cnt   <= '0;
`ifdef MAGMA_DEC_CBC_EN
            c_lat <= in_data;
`endif
          end
        end
        ROUND: begin
          if (cnt != 6'd32) begin
            left  <= right;
            right <= new_right;
            cnt   <= cnt + 6'd1;
          end else begin
            // Final round is already unswapped by reading the halves as {right, left}
`ifdef MAGMA_DEC_CBC_EN
            out_data <= {right, left} ^ chain;
`else
            out_data <= {right, left};
`endif
            out_valid <= 1'b1;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
`ifdef MAGMA_DEC_CBC_EN
            chain     <= c_lat;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_magma_dec_stream.sv
// Directed bench for magma_dec_stream: reset, ECB vector, backpressure, mid-run reset, key change, streaming.
// Define MAGMA_DEC_CBC_EN to also exercise CBC chaining.
module tb_magma_dec_stream;

  logic         clk = 1'b0;
  logic         reset_;
  logic [255:0] key;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic         busy;
`ifdef MAGMA_DEC_CBC_EN
  logic [63:0]  iv;
  logic         iv_load;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [255:0] KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [63:0]  CT  = 64'h4ee901e5c2d8ca3d;
  localparam logic [63:0]  PT  = 64'hfedcba9876543210;

  always #5 clk = ~clk;

  magma_dec_stream dut (
    .clk       (clk),
    .reset_    (reset_),
    .key       (key),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef MAGMA_DEC_CBC_EN
    .iv        (iv),
    .iv_load   (iv_load),
`endif
    .busy      (busy)
  );

  // All driving and sampling happens on the falling edge.
  task automatic offer(input logic [63:0] c, output bit ok);
    ok = 1'b0;
    in_data  = c;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic decrypt(input logic [63:0] c, output int lat, output logic [63:0] d);
    bit ok;
    offer(c, ok);
    if (ok) wait_out(lat);
    else    lat = -1;
    d = out_data;
    handshake();
  endtask

  task automatic test_reset();
    reset_ = 1'b1; in_valid = 1'b0; out_ready = 1'b0; key = KEY; in_data = '0;
    repeat (3) @(negedge clk);
    n_chk++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (out_data !== 64'h0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
    reset_ = 1'b0;
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_ecb();
    int lat;
    logic [63:0] d;
    decrypt(CT, lat, d);
    n_chk++; if (lat !== 33) $display("FAIL ecb_latency: got %0d want 33", lat); else n_pass++;
    n_chk++; if (d !== PT) $display("FAIL ecb_data: got %h want %h", d, PT); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL ecb_valid_drop: got %b want 0", out_valid); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL ecb_idle_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    offer(CT, ok);
    wait_out(lat);
    n_chk++; if (lat !== 33) $display("FAIL bp_latency: got %0d want 33", lat); else n_pass++;
    in_data  = 64'h2b073f0494f372a0;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_chk++;
      if ({out_valid, in_ready, busy, out_data} !== {1'b1, 1'b0, 1'b1, PT})
        $display("FAIL bp_hold cycle %0d: got v=%b r=%b b=%b d=%h want v=1 r=0 b=1 d=%h",
                 i, out_valid, in_ready, busy, out_data, PT);
      else n_pass++;
    end
    handshake();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL bp_valid_drop: got %b want 0", out_valid); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    n_chk++; if (busy !== 1'b1) $display("FAIL bp_second_accept: got busy %b want 1", busy); else n_pass++;
    wait_out(lat);
    n_chk++; if (lat !== 33) $display("FAIL bp_second_latency: got %0d want 33", lat); else n_pass++;
    n_chk++; if (out_data !== 64'h92def06b3c130a59) $display("FAIL bp_second_data: got %h want 92def06b3c130a59", out_data); else n_pass++;
    handshake();
    repeat (3) @(negedge clk);
    n_chk++; if ({out_valid, busy} !== 2'b00) $display("FAIL bp_no_dup: got v=%b b=%b want 00", out_valid, busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    int lat;
    logic [63:0] d;
    offer(CT, ok);
    repeat (10) @(negedge clk);
    reset_ = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({out_valid, busy, in_ready, out_data} !== {3'b000, 64'h0})
      $display("FAIL midreset_state: got v=%b b=%b r=%b d=%h want all 0", out_valid, busy, in_ready, out_data);
    else n_pass++;
    reset_ = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_chk++; if (seen !== 1'b0) $display("FAIL midreset_aborted: got out_valid seen %b want 0", seen); else n_pass++;
    decrypt(CT, lat, d);
    n_chk++; if (lat !== 33) $display("FAIL midreset_fresh_latency: got %0d want 33", lat); else n_pass++;
    n_chk++; if (d !== PT) $display("FAIL midreset_fresh_data: got %h want %h", d, PT); else n_pass++;
  endtask

  task automatic test_key_change();
    bit ok;
    int lat;
    offer(CT, ok);
    key     = ~KEY;
    in_data = 64'h0123456789abcdef;
    repeat (7) @(negedge clk);
    key     = 256'h0;
    wait_out(lat);
    n_chk++; if (lat !== 26) $display("FAIL keychg_latency: got %0d want 26", lat); else n_pass++;
    n_chk++; if (out_data !== PT) $display("FAIL keychg_data: got %h want %h", out_data, PT); else n_pass++;
    handshake();
    key = KEY;
  endtask

  task automatic test_back_to_back();
    logic [63:0] ct4 [4];
    logic [63:0] pt4 [4];
    logic [63:0] got [4];
    int t_out [4];
    int idx;
    int n_out;
    bit took;
    ct4[0] = 64'h2b073f0494f372a0; pt4[0] = 64'h92def06b3c130a59;
    ct4[1] = 64'hde70e715d3556e48; pt4[1] = 64'hdb54c704f8189d20;
    ct4[2] = 64'h11d8d9e9eacfbc1e; pt4[2] = 64'h4a98fb2e67a8024c;
    ct4[3] = 64'h7c68260996c67efb; pt4[3] = 64'h8912409b17b57e41;
    idx = 0; n_out = 0;
    in_data = ct4[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 400 && n_out < 4; c++) begin
      took = in_valid && in_ready;
      if (out_valid) begin
        got[n_out]   = out_data;
        t_out[n_out] = c;
        n_out++;
      end
      @(negedge clk);
      if (took) begin
        idx++;
        if (idx < 4) in_data = ct4[idx];
        else         in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_chk++; if (n_out !== 4) $display("FAIL b2b_count: got %0d want 4", n_out); else n_pass++;
    for (int i = 0; i < n_out; i++) begin
      n_chk++; if (got[i] !== pt4[i]) $display("FAIL b2b_data[%0d]: got %h want %h", i, got[i], pt4[i]); else n_pass++;
    end
    n_chk++; if (n_out > 0 && t_out[0] !== 34) $display("FAIL b2b_first: got %0d want 34", t_out[0]); else n_pass++;
    for (int i = 1; i < n_out; i++) begin
      n_chk++;
      if (t_out[i] - t_out[i-1] !== 35) $display("FAIL b2b_period[%0d]: got %0d want 35", i, t_out[i] - t_out[i-1]);
      else n_pass++;
    end
    @(negedge clk);
  endtask

`ifdef MAGMA_DEC_CBC_EN
  task automatic test_cbc();
    int lat;
    logic [63:0] d;
    iv = 64'h0; iv_load = 1'b1;
    @(negedge clk);
    iv_load = 1'b0;
    decrypt(CT, lat, d);
    n_chk++; if (d !== PT) $display("FAIL cbc_block1: got %h want %h", d, PT); else n_pass++;
    decrypt(CT, lat, d);
    n_chk++; if (d !== 64'hb035bb7db48cf82d) $display("FAIL cbc_block2: got %h want b035bb7db48cf82d", d); else n_pass++;
    iv_load = 1'b1;
  endtask
`endif

  initial begin
`ifdef MAGMA_DEC_CBC_EN
    // Reloading a zero chain on every IDLE cycle makes the plain tests behave as ECB
    iv = 64'h0; iv_load = 1'b1;
`endif
    test_reset();
    test_ecb();
    test_backpressure();
    test_reset_mid();
    test_key_change();
    test_back_to_back();
`ifdef MAGMA_DEC_CBC_EN
    test_cbc();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
